// File: rtl/dot_product_feeder.sv
// -----------------------------------------------------------------------------
// dot_product_feeder
//   Serial-to-parallel front end for the DotProduct reduction tree. Collects
//   N elements of vector A then N elements of vector B, freezes both operand
//   registers for SETTLE edges while the tree resolves, registers the scalar
//   result and offers it on a valid/ready port.
//
// Ports
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   clear      : synchronous abort of partial vector / pending result
//   in_valid   : element valid            in_ready  : element accepted
//   in_data    : 27-bit float (s | e[8] bias 127 | m[18])
//   out_valid  : result valid             out_ready : result consumed
//   out_data   : registered dot product
//   busy       : not idle (idle = LOAD_A with no element collected)
//
// DotProduct
//   Combinational N-lane multiply + pairwise adder tree on the same 27-bit
//   float format. No denormals (exponent 0 is zero), truncating rounding,
//   exponent overflow saturates to infinity.
// -----------------------------------------------------------------------------

module DotProduct #(
    parameter int N = 32
) (
    input  logic [27*N-1:0] i_a,
    input  logic [27*N-1:0] i_b,
    output logic [26:0]     o_out
);

    function automatic logic [26:0] fp_mul(input logic [26:0] a, input logic [26:0] b);
        logic [37:0] prod;
        logic [17:0] m;
        int          e;
        if (a[25:18] == 8'd0 || b[25:18] == 8'd0) return '0;
        prod = 38'({1'b1, a[17:0]}) * 38'({1'b1, b[17:0]});
        e    = int'(a[25:18]) + int'(b[25:18]) - 127;
        if (prod[37]) begin
            m = prod[36:19];
            e = e + 1;
        end else begin
            m = prod[35:18];
        end
        if (e <= 0)   return '0;
        if (e >= 255) return {a[26] ^ b[26], 8'hFF, 18'd0};
        return {a[26] ^ b[26], 8'(e), m};
    endfunction

    function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
        logic [26:0] big;
        logic [26:0] sml;
        logic [21:0] mb;
        logic [21:0] ms;
        logic [22:0] sum;
        int          e;
        int          d;
        if (a[25:18] == 8'd0) return b;
        if (b[25:18] == 8'd0) return a;
        if (a[25:0] >= b[25:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        // Three guard bits keep the aligned smaller operand's shifted-out bits
        // available for the subtract/renormalise path.
        mb = {1'b1, big[17:0], 3'b000};
        ms = {1'b1, sml[17:0], 3'b000};
        d  = int'(big[25:18]) - int'(sml[25:18]);
        ms = (d > 21) ? '0 : (ms >> d);
        e  = int'(big[25:18]);
        if (big[26] == sml[26]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[22]) begin
                sum = sum >> 1;
                e   = e + 1;
            end
        end else begin
            sum = {1'b0, mb} - {1'b0, ms};
            if (sum == '0) return '0;
            for (int unsigned i = 0; i < 21; i++) begin
                if (!sum[21]) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        if (e <= 0)   return '0;
        if (e >= 255) return {big[26], 8'hFF, 18'd0};
        return {big[26], 8'(e), sum[20:3]};
    endfunction

    // Heap-ordered tree: leaves N..2N-1 are lane products, node j sums its
    // children 2j and 2j+1, node 1 is the root.
    function automatic logic [26:0] fp_dot(input logic [27*N-1:0] a, input logic [27*N-1:0] b);
        logic [26:0] node [1:2*N-1];
        for (int unsigned l = 0; l < N; l++) begin
            node[N+l] = fp_mul(a[l*27 +: 27], b[l*27 +: 27]);
        end
        for (int unsigned j = N - 1; j >= 1; j--) begin
            node[j] = fp_add(node[2*j], node[2*j+1]);
        end
        return node[1];
    endfunction

    assign o_out = fp_dot(i_a, i_b);

endmodule

module dot_product_feeder #(
    parameter int N      = 32,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] out_data,
    output logic        busy
);

    localparam int IDXW = $clog2(N);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);
    localparam logic [3:0]      SCNT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [3:0]        r_scnt;
    logic [27*N-1:0]   r_a;
    logic [27*N-1:0]   r_b;
    logic [26:0]       r_out_data;
    logic [26:0]       w_dot;
    logic              w_accept;
    logic              w_last_elem;
    logic              w_settle_done;

    DotProduct #(.N(N)) u_dot (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_out (w_dot)
    );

    assign w_last_elem   = (r_idx == IDX_LAST);
    assign w_settle_done = (r_scnt == SCNT_LAST);
    assign out_data      = r_out_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake decode depends only on registered state, never on in_valid
    // or out_ready, so neither ready nor busy has a combinational input path.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                in_ready = 1'b1;
                busy     = (r_idx != '0);
                w_accept = in_valid;
                if (in_valid && w_last_elem) w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_last_elem) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_settle_done) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_LOAD_A;
            end
            default: w_state_nxt = S_LOAD_A;
        endcase
        if (clear) w_state_nxt = S_LOAD_A;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx      <= '0;
            r_scnt     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_out_data <= '0;
        end else if (clear) begin
            // out_data deliberately retains its last value across an abort.
            r_idx  <= '0;
            r_scnt <= '0;
        end else begin
            case (r_state)
                S_LOAD_A: begin
                    if (w_accept) begin
                        for (int unsigned l = 0; l < N; l++) begin
                            if (r_idx == IDXW'(l)) r_a[l*27 +: 27] <= in_data;
                        end
                        r_idx <= w_last_elem ? '0 : r_idx + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (w_accept) begin
                        for (int unsigned l = 0; l < N; l++) begin
                            if (r_idx == IDXW'(l)) r_b[l*27 +: 27] <= in_data;
                        end
                        r_idx <= w_last_elem ? '0 : r_idx + 1'b1;
                        if (w_last_elem) r_scnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_done) begin
                        r_out_data <= w_dot;
                        r_scnt     <= '0;
                    end else begin
                        r_scnt <= r_scnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) r_idx <= '0;
                end
                default: begin
                    r_idx  <= '0;
                    r_scnt <= '0;
                end
            endcase
        end
    end

endmodule
